// File: rtl/instr_data_mem_responder.sv
// Memory-side responder for the pipelined core: registered instruction fetch,
// combinational data load, synchronous data store, plus a byte-stream boot loader
// that fills memory from word 0 before the core is released.
module instr_data_mem_responder #(
  parameter int unsigned AW      = 11,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 2048,
  parameter bit          BOOT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_addr,
  input  logic          im_oen,
  output logic [DW-1:0] ir,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          dm_oen,
  input  logic          dm_wen,
  output logic [DW-1:0] d_rdata,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          boot_done,
  output logic          err
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthA   = (AW + 1)'(DEPTH);

  typedef enum logic {StBoot, StRun} state_e;

  state_e          r_state;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_lane_buf;   // lanes 0..2 of the word being assembled
  logic [AW:0]     r_waddr;      // one extra bit so it can reach DEPTH
  logic [DW-1:0]   r_ir;
  logic            r_err;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_ld_accept;
  logic            w_word_done;
  logic            w_boot_room;
  logic            w_i_in;
  logic            w_d_in;
  logic            w_store;
  logic [31:0]     w_word32;
  logic [DW-1:0]   w_boot_word;
  logic            w_mem_we;
  logic [IdxW-1:0] w_mem_waddr;
  logic [DW-1:0]   w_mem_wdata;
  logic [DW-1:0]   w_fetch_data;

  assign w_ld_accept = ld_valid && (r_state == StBoot);
  assign w_word_done = w_ld_accept && ((r_byte_cnt == 2'd3) || ld_last);
  assign w_boot_room = (r_waddr < DepthA);
  assign w_i_in      = ({1'b0, i_addr} < DepthA);
  assign w_d_in      = ({1'b0, d_addr} < DepthA);
  assign w_store     = (r_state == StRun) && !dm_wen && w_d_in;

  // Insert the incoming byte into its lane; lanes above it are still zero.
  always_comb begin
    w_word32 = {8'h00, r_lane_buf};
    w_word32[{r_byte_cnt, 3'b000} +: 8] = ld_data;
  end

  assign w_boot_word = DW'(w_word32);

  // Single memory write port shared by the loader (BOOT) and core stores (RUN).
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = '0;
    if (rst_n) begin
      if (w_word_done && w_boot_room) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_waddr[IdxW-1:0];
        w_mem_wdata = w_boot_word;
      end else if (w_store) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = d_addr[IdxW-1:0];
        w_mem_wdata = d_wdata;
      end
    end
  end

  // Memory array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Fetch data with write-first bypass when a store hits the fetched word.
  always_comb begin
    if (!w_i_in) begin
      w_fetch_data = '0;
    end else if (w_store && (d_addr == i_addr)) begin
      w_fetch_data = d_wdata;
    end else begin
      w_fetch_data = r_mem[i_addr[IdxW-1:0]];
    end
  end

  // Boot/run FSM with loader bookkeeping and the registered instruction output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= BOOT_EN ? StBoot : StRun;
      r_byte_cnt <= 2'd0;
      r_lane_buf <= '0;
      r_waddr    <= '0;
      r_ir       <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        StBoot: begin
          if (w_ld_accept) begin
            if (w_word_done) begin
              r_byte_cnt <= 2'd0;
              r_lane_buf <= '0;
              if (w_boot_room) begin
                r_waddr <= r_waddr + 1'b1;
              end else begin
                r_err <= 1'b1;
              end
              if (ld_last) begin
                r_state <= StRun;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_lane_buf <= w_word32[23:0];
            end
          end
        end
        StRun: begin
          if (!im_oen) begin
            r_ir <= w_fetch_data;
          end
        end
      endcase
    end
  end

  assign ir        = r_ir;
  assign err       = r_err;
  assign ld_ready  = (r_state == StBoot);
  assign boot_done = (r_state == StRun);
  assign d_rdata   = ((r_state == StRun) && !dm_oen && w_d_in) ? r_mem[d_addr[IdxW-1:0]] : '0;

endmodule
